// File: rtl/scarv_cpu_cop_initiator_if.sv
// CPU <-> COP instruction interface.
// master = CPU-side initiator, slave = co-processor.
interface scarv_cpu_cop_initiator_if;
    logic        cpu_insn_req;
    logic        cop_insn_ack;
    logic        cpu_abort_req;
    logic [31:0] cpu_insn_enc;
    logic [31:0] cpu_rs1;
    logic        cop_wen;
    logic [4:0]  cop_waddr;
    logic [31:0] cop_wdata;
    logic [2:0]  cop_result;
    logic        cop_insn_rsp;
    logic        cpu_insn_ack;

    modport master (
        output cpu_insn_req, cpu_abort_req, cpu_insn_enc, cpu_rs1,
        output cpu_insn_ack,
        input  cop_insn_ack, cop_wen, cop_waddr, cop_wdata,
        input  cop_result, cop_insn_rsp
    );

    modport slave (
        input  cpu_insn_req, cpu_abort_req, cpu_insn_enc, cpu_rs1,
        input  cpu_insn_ack,
        output cop_insn_ack, cop_wen, cop_waddr, cop_wdata,
        output cop_result, cop_insn_rsp
    );
endinterface

// File: rtl/scarv_cpu_cop_initiator.sv
// CPU-side initiator: issues one instruction to the COP, collects the
// response for write-back, with host abort and a watchdog timeout.
module scarv_cpu_cop_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [2:0]  TIMEOUT_RESULT = 3'b111
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [31:0] issue_enc,
    input  logic [31:0] issue_rs1,
    input  logic        issue_abort,
    output logic        busy,
    scarv_cpu_cop_initiator_if.master cop,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic        wb_wen,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic [2:0]  wb_result
);

    localparam int TW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT, DONE, ABORT
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [TW-1:0] timer;
    logic          timed_out;
    logic          timeout;
    logic          in_flight;
    logic [31:0]   enc_q;
    logic [31:0]   rs1_q;

    assign in_flight = (state == REQ) || (state == WAIT);
    assign timeout   = (TIMEOUT_CYCLES != 0) && (timer == TLAST);

    always_ff @(posedge g_clk) begin
        if (g_reset) state <= IDLE;
        else         state <= state_n;
    end

    // Host abort beats ack/rsp, which in turn beat the watchdog.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (issue_valid) state_n = REQ;
            REQ: begin
                if (issue_abort)           state_n = ABORT;
                else if (cop.cop_insn_ack) state_n = WAIT;
                else if (timeout)          state_n = ABORT;
            end
            WAIT: begin
                if (issue_abort)           state_n = ABORT;
                else if (cop.cop_insn_rsp) state_n = DONE;
                else if (timeout)          state_n = ABORT;
            end
            DONE:  if (wb_ready) state_n = IDLE;
            ABORT: state_n = timed_out ? DONE : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        issue_ready       = 1'b0;
        busy              = 1'b1;
        cop.cpu_insn_req  = 1'b0;
        cop.cpu_insn_ack  = 1'b0;
        cop.cpu_abort_req = 1'b0;
        wb_valid          = 1'b0;
        unique case (state)
            IDLE: begin
                issue_ready = 1'b1;
                busy        = 1'b0;
            end
            REQ:   cop.cpu_insn_req  = 1'b1;
            WAIT:  cop.cpu_insn_ack  = 1'b1;
            DONE:  wb_valid          = 1'b1;
            ABORT: cop.cpu_abort_req = 1'b1;
            default: begin
                issue_ready = 1'b0;
            end
        endcase
    end

    assign cop.cpu_insn_enc = enc_q;
    assign cop.cpu_rs1      = rs1_q;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            enc_q     <= '0;
            rs1_q     <= '0;
            timer     <= '0;
            timed_out <= 1'b0;
            wb_wen    <= 1'b0;
            wb_waddr  <= '0;
            wb_wdata  <= '0;
            wb_result <= '0;
        end else begin
            if (state == IDLE && issue_valid) begin
                enc_q <= issue_enc;
                rs1_q <= issue_rs1;
                timer <= '0;
            end else if (in_flight && timer != '1) begin
                timer <= timer + TW'(1);
            end
            if (in_flight && state_n == ABORT)
                timed_out <= !issue_abort;
            if (state == WAIT && state_n == DONE) begin
                wb_wen    <= cop.cop_wen;
                wb_waddr  <= cop.cop_waddr;
                wb_wdata  <= cop.cop_wdata;
                wb_result <= cop.cop_result;
            end else if (state == ABORT && timed_out) begin
                wb_wen    <= 1'b0;
                wb_waddr  <= '0;
                wb_wdata  <= '0;
                wb_result <= TIMEOUT_RESULT;
            end
        end
    end

endmodule

// File: tb/tb_scarv_cpu_cop_initiator.sv
// Directed bench for scarv_cpu_cop_initiator.
// Runs with an 8-cycle watchdog.
module tb_scarv_cpu_cop_initiator;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_enc;
    logic [31:0] issue_rs1;
    logic        issue_abort;
    logic        busy;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_wen;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic [2:0]  wb_result;

    int nvec = 0;
    int nerr = 0;

    scarv_cpu_cop_initiator_if cop_if ();

    scarv_cpu_cop_initiator #(
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_RESULT (3'b111)
    ) dut (
        .g_clk       (g_clk),
        .g_reset     (g_reset),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_enc   (issue_enc),
        .issue_rs1   (issue_rs1),
        .issue_abort (issue_abort),
        .busy        (busy),
        .cop         (cop_if.master),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_wen      (wb_wen),
        .wb_waddr    (wb_waddr),
        .wb_wdata    (wb_wdata),
        .wb_result   (wb_result)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] enc,
                         input logic [31:0] rs1);
        issue_valid = 1'b1;
        issue_enc   = enc;
        issue_rs1   = rs1;
        step();
        issue_valid = 1'b0;
    endtask

    task automatic ack_now();
        cop_if.cop_insn_ack = 1'b1;
        step();
        cop_if.cop_insn_ack = 1'b0;
    endtask

    task automatic rsp_now(input logic w, input logic [4:0] a,
                           input logic [31:0] d, input logic [2:0] r);
        cop_if.cop_insn_rsp = 1'b1;
        cop_if.cop_wen      = w;
        cop_if.cop_waddr    = a;
        cop_if.cop_wdata    = d;
        cop_if.cop_result   = r;
        step();
        cop_if.cop_insn_rsp = 1'b0;
        cop_if.cop_wen      = 1'b0;
        cop_if.cop_waddr    = 5'd31;
        cop_if.cop_wdata    = 32'hDEAD_DEAD;
        cop_if.cop_result   = 3'd5;
    endtask

    int reqs;
    int aborts;
    logic seen_abort;

    initial begin
        g_reset             = 1'b1;
        issue_valid         = 1'b0;
        issue_enc           = '0;
        issue_rs1           = '0;
        issue_abort         = 1'b0;
        wb_ready            = 1'b0;
        cop_if.cop_insn_ack = 1'b0;
        cop_if.cop_insn_rsp = 1'b0;
        cop_if.cop_wen      = 1'b0;
        cop_if.cop_waddr    = '0;
        cop_if.cop_wdata    = '0;
        cop_if.cop_result   = '0;
        step();
        step();
        g_reset = 1'b0;

        chk("rst_ready", {31'd0, issue_ready}, 32'd1);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_req",   {31'd0, cop_if.cpu_insn_req}, 32'd0);
        chk("rst_abort", {31'd0, cop_if.cpu_abort_req}, 32'd0);
        chk("rst_wbv",   {31'd0, wb_valid}, 32'd0);
        chk("rst_enc",   cop_if.cpu_insn_enc, 32'd0);
        chk("rst_res",   {29'd0, wb_result}, 32'd0);

        // 1: basic transaction
        issue(32'h0000_100B, 32'h0000_1234);
        chk("t1_req",   {31'd0, cop_if.cpu_insn_req}, 32'd1);
        chk("t1_rdy",   {31'd0, issue_ready}, 32'd0);
        chk("t1_busy",  {31'd0, busy}, 32'd1);
        chk("t1_enc",   cop_if.cpu_insn_enc, 32'h0000_100B);
        chk("t1_rs1",   cop_if.cpu_rs1, 32'h0000_1234);
        step();
        chk("t1_req2",  {31'd0, cop_if.cpu_insn_req}, 32'd1);
        ack_now();
        chk("t1_wack",  {31'd0, cop_if.cpu_insn_ack}, 32'd1);
        chk("t1_wreq",  {31'd0, cop_if.cpu_insn_req}, 32'd0);
        rsp_now(1'b1, 5'd5, 32'h0000_CAFE, 3'd0);
        chk("t1_wbv",   {31'd0, wb_valid}, 32'd1);
        chk("t1_wen",   {31'd0, wb_wen}, 32'd1);
        chk("t1_waddr", {27'd0, wb_waddr}, 32'd5);
        chk("t1_wdata", wb_wdata, 32'h0000_CAFE);
        chk("t1_res",   {29'd0, wb_result}, 32'd0);
        chk("t1_dack",  {31'd0, cop_if.cpu_insn_ack}, 32'd0);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("t1_idle",  {31'd0, issue_ready}, 32'd1);
        chk("t1_wbv0",  {31'd0, wb_valid}, 32'd0);

        // 2: stalled write-back, pending issue held off
        issue(32'h0000_200B, 32'h0000_0055);
        ack_now();
        rsp_now(1'b1, 5'd9, 32'h0000_BEEF, 3'd2);
        issue_valid = 1'b1;
        issue_enc   = 32'h0000_300B;
        issue_rs1   = 32'h0000_0077;
        for (int i = 0; i < 10; i++) begin
            chk("t2_wbv",   {31'd0, wb_valid}, 32'd1);
            chk("t2_wdata", wb_wdata, 32'h0000_BEEF);
            chk("t2_rdy",   {31'd0, issue_ready}, 32'd0);
            step();
        end
        chk("t2_res",   {29'd0, wb_result}, 32'd2);
        chk("t2_waddr", {27'd0, wb_waddr}, 32'd9);
        chk("t2_enc",   cop_if.cpu_insn_enc, 32'h0000_200B);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("t2_idle",  {31'd0, issue_ready}, 32'd1);
        chk("t2_noreq", {31'd0, cop_if.cpu_insn_req}, 32'd0);
        step();
        issue_valid = 1'b0;
        chk("t2_req",   {31'd0, cop_if.cpu_insn_req}, 32'd1);
        chk("t2_enc2",  cop_if.cpu_insn_enc, 32'h0000_300B);

        // 3: COP never acks -> watchdog
        reqs       = 1;
        aborts     = 0;
        seen_abort = 1'b0;
        for (int i = 0; i < 20 && !seen_abort; i++) begin
            step();
            if (cop_if.cpu_insn_req)  reqs++;
            if (cop_if.cpu_abort_req) seen_abort = 1'b1;
        end
        chk("t3_seen",  {31'd0, seen_abort}, 32'd1);
        chk("t3_reqs",  reqs, 32'd8);
        step();
        chk("t3_pulse", {31'd0, cop_if.cpu_abort_req}, 32'd0);
        chk("t3_wbv",   {31'd0, wb_valid}, 32'd1);
        chk("t3_res",   {29'd0, wb_result}, 32'd7);
        chk("t3_wen",   {31'd0, wb_wen}, 32'd0);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("t3_idle",  {31'd0, issue_ready}, 32'd1);

        // 4: host abort in WAIT
        issue(32'h0000_400B, 32'h0000_0001);
        ack_now();
        issue_abort = 1'b1;
        step();
        issue_abort = 1'b0;
        chk("t4_abort", {31'd0, cop_if.cpu_abort_req}, 32'd1);
        chk("t4_ack",   {31'd0, cop_if.cpu_insn_ack}, 32'd0);
        step();
        chk("t4_pulse", {31'd0, cop_if.cpu_abort_req}, 32'd0);
        chk("t4_idle",  {31'd0, issue_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t4_wbv", {31'd0, wb_valid}, 32'd0);
            step();
        end

        // 5: response on the last watchdog cycle wins
        issue(32'h0000_500B, 32'h0000_0002);
        ack_now();
        aborts = 0;
        for (int i = 0; i < 6; i++) begin
            if (cop_if.cpu_abort_req) aborts++;
            step();
        end
        chk("t5_wait",  {31'd0, cop_if.cpu_insn_ack}, 32'd1);
        rsp_now(1'b1, 5'd17, 32'h1357_9BDF, 3'd1);
        chk("t5_noab",  aborts + {31'd0, cop_if.cpu_abort_req}, 32'd0);
        chk("t5_wbv",   {31'd0, wb_valid}, 32'd1);
        chk("t5_wen",   {31'd0, wb_wen}, 32'd1);
        chk("t5_wdata", wb_wdata, 32'h1357_9BDF);
        chk("t5_res",   {29'd0, wb_result}, 32'd1);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;

        // 6: abort ignored in IDLE, then reset in WAIT
        issue_abort = 1'b1;
        issue(32'h0000_600B, 32'h0000_0003);
        issue_abort = 1'b0;
        chk("t6_req",   {31'd0, cop_if.cpu_insn_req}, 32'd1);
        ack_now();
        chk("t6_wait",  {31'd0, cop_if.cpu_insn_ack}, 32'd1);
        g_reset = 1'b1;
        step();
        g_reset = 1'b0;
        chk("t6_rdy",   {31'd0, issue_ready}, 32'd1);
        chk("t6_req0",  {31'd0, cop_if.cpu_insn_req}, 32'd0);
        chk("t6_ack0",  {31'd0, cop_if.cpu_insn_ack}, 32'd0);
        chk("t6_ab0",   {31'd0, cop_if.cpu_abort_req}, 32'd0);
        chk("t6_enc0",  cop_if.cpu_insn_enc, 32'd0);
        chk("t6_rs10",  cop_if.cpu_rs1, 32'd0);
        chk("t6_wbv0",  {31'd0, wb_valid}, 32'd0);
        step();
        chk("t6_ab1",   {31'd0, cop_if.cpu_abort_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
